// File: rtl/memory_arbiter_pkg.sv
// Shared port identifiers and the tag type for the memory arbiter.
// The tag records which requester a read belongs to while it is in flight.
package memory_arbiter_pkg;
  typedef logic port_tag_t;
  localparam port_tag_t PORT_CPU = 1'b0;
  localparam port_tag_t PORT_DMA = 1'b1;
endpackage

// File: rtl/memory_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer.
// Grants are forced off while reset is held.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RSTb,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  import memory_arbiter_pkg::*;

  port_tag_t r_last;

  always_comb begin
    gnt = 2'b00;
    if (RSTb) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (r_last == PORT_CPU) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointing at DMA after reset hands the first tie to the CPU.
  always_ff @(posedge CLK) begin
    if (!RSTb)       r_last <= PORT_DMA;
    else if (gnt[1]) r_last <= PORT_DMA;
    else if (gnt[0]) r_last <= PORT_CPU;
  end
endmodule

// File: rtl/memory_arbiter.sv
// Two-port front end for a single-port synchronous RAM: arbitrates, registers
// the winning access onto the RAM bus and returns read data with a valid pulse.
module memory_arbiter #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    REQ0,
  input  logic                    WR0,
  input  logic [ADDRESS_BITS-1:0] ADDR0,
  input  logic [BITS-1:0]         WDATA0,
  output logic                    GNT0,
  output logic                    RVALID0,
  output logic [BITS-1:0]         RDATA0,
  input  logic                    REQ1,
  input  logic                    WR1,
  input  logic [ADDRESS_BITS-1:0] ADDR1,
  input  logic [BITS-1:0]         WDATA1,
  output logic                    GNT1,
  output logic                    RVALID1,
  output logic [BITS-1:0]         RDATA1,
  output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
  output logic [BITS-1:0]         MEM_DATA_IN,
  output logic                    MEM_WRb,
  input  logic [BITS-1:0]         MEM_DATA_OUT
);
  import memory_arbiter_pkg::*;

  logic [1:0]              w_gnt;
  logic                    w_any;
  port_tag_t               w_sel;
  logic                    w_wr;
  logic [ADDRESS_BITS-1:0] w_addr;
  logic [BITS-1:0]         w_wdata;

  logic [ADDRESS_BITS-1:0] r_mem_addr;
  logic [BITS-1:0]         r_mem_din;
  logic                    r_mem_wrb;
  logic                    r_s1_vld;
  port_tag_t               r_s1_tag;
  logic                    r_s2_vld;
  port_tag_t               r_s2_tag;

  rr_arb2 u_arb (
    .CLK  (CLK),
    .RSTb (RSTb),
    .req  ({REQ1, REQ0}),
    .gnt  (w_gnt)
  );

  assign GNT0  = w_gnt[0];
  assign GNT1  = w_gnt[1];
  assign w_any = |w_gnt;
  assign w_sel = w_gnt[1] ? PORT_DMA : PORT_CPU;

  assign w_wr    = (w_sel == PORT_DMA) ? WR1    : WR0;
  assign w_addr  = (w_sel == PORT_DMA) ? ADDR1  : ADDR0;
  assign w_wdata = (w_sel == PORT_DMA) ? WDATA1 : WDATA0;

  // Address/data hold when idle; only the write strobe is forced inactive.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_wrb  <= 1'b1;
      r_s1_vld   <= 1'b0;
      r_s1_tag   <= PORT_CPU;
      r_s2_vld   <= 1'b0;
      r_s2_tag   <= PORT_CPU;
    end else begin
      if (w_any) begin
        r_mem_addr <= w_addr;
        r_mem_din  <= w_wdata;
        r_mem_wrb  <= ~w_wr;
      end else begin
        r_mem_wrb  <= 1'b1;
      end
      r_s1_vld <= w_any & ~w_wr;
      r_s1_tag <= w_sel;
      r_s2_vld <= r_s1_vld;
      r_s2_tag <= r_s1_tag;
    end
  end

  assign MEM_ADDRESS = r_mem_addr;
  assign MEM_DATA_IN = r_mem_din;
  assign MEM_WRb     = r_mem_wrb;

  // RAM output register lines up with stage 2, so data passes straight through.
  assign RVALID0 = r_s2_vld & (r_s2_tag == PORT_CPU);
  assign RVALID1 = r_s2_vld & (r_s2_tag == PORT_DMA);
  assign RDATA0  = MEM_DATA_OUT;
  assign RDATA1  = MEM_DATA_OUT;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural registered-read RAM.
// Read-valid events are logged with their cycle number and checked per scenario.
module tb_memory_arbiter;
  logic        CLK;
  logic        RSTb;
  logic        REQ0, WR0, GNT0, RVALID0;
  logic [15:0] ADDR0, WDATA0, RDATA0;
  logic        REQ1, WR1, GNT1, RVALID1;
  logic [15:0] ADDR1, WDATA1, RDATA1;
  logic [15:0] MEM_ADDRESS, MEM_DATA_IN, MEM_DATA_OUT;
  logic        MEM_WRb;

  int n_total = 0;
  int n_bad   = 0;
  int cyc_n   = 0;
  logic rst_drv = 1'b0;

  int          ev_cyc[$];
  logic        ev_port[$];
  logic [15:0] ev_dat[$];

  logic [15:0] mem [0:65535];

  memory_arbiter #(.BITS(16), .ADDRESS_BITS(16)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .REQ0(REQ0), .WR0(WR0), .ADDR0(ADDR0), .WDATA0(WDATA0),
    .GNT0(GNT0), .RVALID0(RVALID0), .RDATA0(RDATA0),
    .REQ1(REQ1), .WR1(WR1), .ADDR1(ADDR1), .WDATA1(WDATA1),
    .GNT1(GNT1), .RVALID1(RVALID1), .RDATA1(RDATA1),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA_IN(MEM_DATA_IN),
    .MEM_WRb(MEM_WRb), .MEM_DATA_OUT(MEM_DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port RAM: no reset, active-low write, registered read.
  always @(posedge CLK) begin
    if (!MEM_WRb) mem[MEM_ADDRESS] <= MEM_DATA_IN;
    MEM_DATA_OUT <= mem[MEM_ADDRESS];
  end

  always @(negedge CLK) begin
    cyc_n = cyc_n + 1;
    if (RVALID0) begin ev_cyc.push_back(cyc_n); ev_port.push_back(1'b0); ev_dat.push_back(RDATA0); end
    if (RVALID1) begin ev_cyc.push_back(cyc_n); ev_port.push_back(1'b1); ev_dat.push_back(RDATA1); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                     input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
    @(negedge CLK);
    RSTb = rst_drv;
    REQ0 = r0; WR0 = w0; ADDR0 = a0; WDATA0 = d0;
    REQ1 = r1; WR1 = w1; ADDR1 = a1; WDATA1 = d1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic clr();
    ev_cyc.delete(); ev_port.delete(); ev_dat.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int g_cyc[4];
    RSTb = 1'b0;
    REQ0 = 1'b0; WR0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
    REQ1 = 1'b0; WR1 = 1'b0; ADDR1 = '0; WDATA1 = '0;

    // Reset held with a pending port-0 write.
    for (int k = 0; k < 3; k++) drv(1'b1, 1'b1, 16'h0001, 16'h1111, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rst_gnt0", 32'(GNT0), 32'd0);
    chk("rst_gnt1", 32'(GNT1), 32'd0);
    chk("rst_wrb", 32'(MEM_WRb), 32'd1);
    chk("rst_addr", 32'(MEM_ADDRESS), 32'h0);
    chk("rst_din", 32'(MEM_DATA_IN), 32'h0);
    chk("rst_rv0", 32'(RVALID0), 32'd0);
    chk("rst_rv1", 32'(RVALID1), 32'd0);

    rst_drv = 1'b1;
    drv(1'b1, 1'b1, 16'h0001, 16'h1111, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rel_gnt0", 32'(GNT0), 32'd1);
    drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0002, 16'h2222);
    chk("pre_gnt1", 32'(GNT1), 32'd1);
    chk("bus_wrb", 32'(MEM_WRb), 32'd0);
    chk("bus_addr", 32'(MEM_ADDRESS), 32'h0001);
    chk("bus_din", 32'(MEM_DATA_IN), 32'h1111);
    for (int i = 0; i < 8; i++)
      drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'(16'h0100 + i), 16'(16'h5A00 + i));
    idle(3);
    chk("pre_noread", 32'(ev_cyc.size()), 32'd0);
    clr();

    // Contention: last grant was DMA, so CPU wins first, then alternate.
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
      g_cyc[i] = cyc_n;
      chk("cont_gnt0", 32'(GNT0), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_gnt1", 32'(GNT1), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    idle(3);
    chk("cont_cnt", 32'(ev_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (i < ev_cyc.size()) begin
      chk("cont_port", 32'(ev_port[i]), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("cont_data", 32'(ev_dat[i]), (i % 2 == 1) ? 32'h2222 : 32'h1111);
      chk("cont_lat", 32'(ev_cyc[i]), 32'(g_cyc[i] + 2));
    end
    clr();

    // Write then immediate read of the same address.
    drv(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("wr_gnt0", 32'(GNT0), 32'd1);
    drv(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rd_gnt0", 32'(GNT0), 32'd1);
    g = cyc_n;
    idle(3);
    chk("raw_cnt", 32'(ev_cyc.size()), 32'd1);
    if (ev_cyc.size() > 0) begin
      chk("raw_port", 32'(ev_port[0]), 32'd0);
      chk("raw_data", 32'(ev_dat[0]), 32'hBEEF);
      chk("raw_lat", 32'(ev_cyc[0]), 32'(g + 2));
    end
    clr();

    // DMA streams 8 back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'(16'h0100 + i), 16'h0);
      if (i == 0) g = cyc_n;
      chk("b2b_gnt1", 32'(GNT1), 32'd1);
    end
    idle(3);
    chk("b2b_cnt", 32'(ev_cyc.size()), 32'd8);
    for (int i = 0; i < 8; i++) if (i < ev_cyc.size()) begin
      chk("b2b_port", 32'(ev_port[i]), 32'd1);
      chk("b2b_data", 32'(ev_dat[i]), 32'(16'h5A00 + i));
      chk("b2b_lat", 32'(ev_cyc[i]), 32'(g + 2 + i));
    end
    clr();

    // DMA pulses a request for one cycle while the CPU takes the grant.
    drv(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    chk("wd_gnt0", 32'(GNT0), 32'd1);
    chk("wd_gnt1a", 32'(GNT1), 32'd0);
    drv(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("wd_gnt1b", 32'(GNT1), 32'd0);
    chk("wd_wrb_a", 32'(MEM_WRb), 32'd1);
    idle(1);
    chk("wd_wrb_b", 32'(MEM_WRb), 32'd1);
    idle(3);
    chk("wd_cnt", 32'(ev_cyc.size()), 32'd2);
    for (int i = 0; i < 2; i++) if (i < ev_cyc.size()) begin
      chk("wd_port", 32'(ev_port[i]), 32'd0);
      chk("wd_data", 32'(ev_dat[i]), 32'h1111);
    end
    clr();

    // Reset lands while a write is on the bus and a read has just been granted.
    drv(1'b1, 1'b1, 16'h0020, 16'h00AA, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rm_gnt0", 32'(GNT0), 32'd1);
    drv(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    chk("rm_gnt1", 32'(GNT1), 32'd1);
    chk("rm_wrb_bus", 32'(MEM_WRb), 32'd0);
    rst_drv = 1'b0;
    RSTb = 1'b0;
    idle(1);
    chk("rm_wrb_rst", 32'(MEM_WRb), 32'd1);
    idle(1);
    rst_drv = 1'b1;
    idle(4);
    chk("rm_norv", 32'(ev_cyc.size()), 32'd0);
    drv(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rm_rd_gnt0", 32'(GNT0), 32'd1);
    g = cyc_n;
    idle(3);
    chk("rm_cnt", 32'(ev_cyc.size()), 32'd1);
    if (ev_cyc.size() > 0) begin
      chk("rm_port", 32'(ev_port[0]), 32'd0);
      chk("rm_data", 32'(ev_dat[0]), 32'h00AA);
      chk("rm_lat", 32'(ev_cyc[0]), 32'(g + 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Two-requester front end placed directly upstream of the single-port synchronous RAM (active-low write strobe, registered read data).
- Port 0 is the CPU load/store path. Port 1 is the DMA/loader path.
- Arbitrates round-robin, registers the winning access onto the RAM bus, and routes read data back to the requester with a per-port valid pulse.
- Sustains one access per clock.

Parameters:
- BITS, 16, data word width; must match RAM BITS.
- ADDRESS_BITS, 16, address width; must match RAM ADDRESS_BITS.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RSTb  in  1  reset; synchronous, active-low.
- REQ0  in  1  port 0 access request; held until GNT0.
- WR0  in  1  port 0 write (1) / read (0).
- ADDR0  in  ADDRESS_BITS  port 0 address.
- WDATA0  in  BITS  port 0 write data.
- GNT0  out  1  port 0 request accepted this cycle (combinational).
- RVALID0  out  1  port 0 read data valid (one-cycle pulse).
- RDATA0  out  BITS  port 0 read data.
- REQ1, WR1, ADDR1, WDATA1, GNT1, RVALID1, RDATA1: same as port 0, for port 1.
- MEM_ADDRESS  out  ADDRESS_BITS  to RAM ADDRESS (registered).
- MEM_DATA_IN  out  BITS  to RAM DATA_IN (registered).
- MEM_WRb  out  1  to RAM WRb, active-low (registered).
- MEM_DATA_OUT  in  BITS  from RAM DATA_OUT.

Behaviour:
- Reset, RSTb=0 at a rising edge:
  - MEM_WRb=1, MEM_ADDRESS=0, MEM_DATA_IN=0.
  - Pipeline valid bits cleared, so RVALID0=RVALID1=0.
  - Round-robin pointer set to favour port 0.
  - GNT0/GNT1 forced 0 while RSTb=0.
- Arbitration (combinational, cycle N):
  - Only one REQ high: that port is granted.
  - Both high: the port not granted most recently wins.
  - The pointer updates only on a grant.
  - Exactly one GNT max per cycle.
- Stage 1 (edge N+1):
  - Winner's ADDR registered to MEM_ADDRESS and WDATA to MEM_DATA_IN.
  - MEM_WRb = ~WR of the winner.
  - For a read, stage-1 valid=1 and tag=port.
  - No grant in cycle N: MEM_WRb=1, address/data hold previous value, stage-1 valid=0.
- RAM samples at edge N+2: writes commit, or reads land on MEM_DATA_OUT.
- Stage 2 (edge N+2):
  - Stage-1 valid/tag shift to stage 2.
  - During cycle N+2: RVALIDx = stage-2 valid & (tag==x).
  - RDATA0 = RDATA1 = MEM_DATA_OUT, unregistered passthrough.
- Latency and throughput:
  - Read latency is 2 cycles from the grant cycle to RVALID.
  - Back-to-back grants allowed every cycle, from either port.
- Idle bus reads (MEM_WRb=1 with no valid) are harmless: never reported, and RAM dout is ignored.
- Writes produce no RVALID.
- Read-after-write, same address, consecutive grants: the read returns the new data, because the write commits at the edge before the read samples. No forwarding needed.
- Requester rules:
  - REQx/WRx/ADDRx/WDATAx must be stable while REQx=1 and GNTx=0.
  - Dropping REQ before grant is permitted (request withdrawn).
- Reset mid-operation:
  - A write already registered on the bus at the reset edge still commits (RAM has no reset).
  - In-flight reads are discarded, and no RVALID follows reset.
- Address wrap: none; ADDRESS_BITS is passed straight through.

Decomposition:
- Package memory_arbiter_pkg:
  - PORT_CPU=0, PORT_DMA=1 constants.
  - Port-tag type (1 bit).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: CLK, RSTb, req[1:0].
  - Outputs: gnt[1:0] one-hot-or-zero.
  - Internal: last-grant pointer.
- Top holds the request mux, the bus registers and the 2-stage valid/tag pipeline.

Test Plan:
- Reset: hold RSTb=0 with REQ0=1 -> GNT0=0, MEM_WRb=1, RVALID0/1=0. Release -> GNT0=1 on the first cycle.
- Single write then read:
  - Port 0 writes 0xBEEF to 0x0010.
  - Port 0 reads 0x0010 in the next cycle -> RVALID0 two cycles after the read grant, RDATA0=0xBEEF, RVALID1 never set.
- Contention:
  - REQ0=REQ1=1 held for 4 cycles, reads of 0x0001 and 0x0002 -> grants alternate P0,P1,P0,P1.
  - RVALID pulses in the same order, with data matching preloaded 0x1111 and 0x2222.
- Back-to-back:
  - Port 1 streams 8 reads of 0x0100..0x0107 with REQ1 held -> GNT1 high for 8 cycles.
  - 8 consecutive RVALID1 pulses with RDATA1 in address order.
- Reset mid-flight:
  - Port 0 write 0x00AA to 0x0020 is granted in cycle N.
  - Port 1 read is granted in cycle N+1.
  - RSTb=0 at edge N+2 -> no RVALID1 afterwards.
  - A later read of 0x0020 returns 0x00AA.
- Withdrawn request: REQ1 pulses for 1 cycle while port 0 holds the grant -> no GNT1, MEM_WRb stays 1, no RVALID1.
